ahb_lite_slave_mux: RTL and testbench
=====================================

// Module: ahb_lite_slave_mux
// PURPOSE
//  Parametrised AHB-Lite address decoder + slave-response mux for one master and N_SLAVE slaves.
//  Generates one-hot HSEL from HADDR, tracks the data-phase owner, and muxes HREADY/HRESP/HRDATA back.
//  Built-in default slave: two-cycle ERROR response to unmapped NONSEQ/SEQ transfers.
//  Error counter and captured address for debug.
//  Sits between the RISC master port and the accelerator slave interfaces (ALU, multiplier, ...).
// PARAMETERS
//  N_SLAVE        4                      number of mapped slaves (1..16)
//  W_ADDR         32                     address width
//  W_DATA         32                     data width
//  ADDR_START_MAP {N_SLAVE{32'h0}}       N_SLAVE*W_ADDR base addresses; slave i at [i*W_ADDR+:W_ADDR]
//  ADDR_MASK      {N_SLAVE{32'hFFFFF000}} N_SLAVE*W_ADDR decode masks, same packing
//  W_ERRCNT       16                     width of saturating error counter
// PORTS
//  HCLK          in   1               clock
//  HRESETn       in   1               async reset, active low
//  ma_HADDR      in   W_ADDR          master address
//  ma_HTRANS     in   2               master transfer type
//  out_ma_HREADY out  1               muxed HREADY to master and to all slaves' HREADY input
//  out_ma_HRESP  out  2               muxed response (2'b00 OKAY, 2'b01 ERROR)
//  out_ma_HRDATA out  W_DATA          muxed read data
//  out_sl_HSEL   out  N_SLAVE         one-hot slave select (address phase)
//  sl_HREADY     in   N_SLAVE         per-slave HREADYOUT
//  sl_HRESP      in   N_SLAVE*2       per-slave HRESP, slave i at [i*2+:2]
//  sl_HRDATA     in   N_SLAVE*W_DATA  per-slave HRDATA, slave i at [i*W_DATA+:W_DATA]
//  err_cnt       out  W_ERRCNT        unmapped-access count, saturating
//  err_addr      out  W_ADDR          HADDR of most recent unmapped NONSEQ/SEQ access
//  err_clr       in   1               sync clear of err_cnt and err_addr
// BEHAVIOUR
//  - Decode (combinational): hit[i] = ((ma_HADDR ^ START_i) & MASK_i) == 0.
//    Overlap: lowest index wins. No hit: default slave; out_sl_HSEL = 0.
//  - HSEL is driven from the decode regardless of HTRANS; slaves qualify with HTRANS.
//  - Data-phase owner register d_sel (N_SLAVE+1 bits, one-hot, bit N = default):
//    loaded from the decode when out_ma_HREADY==1, held otherwise.
//  - Reset: d_sel = default, FSM = IDLE, err_cnt = 0, err_addr = 0.
//  - Response mux, selected by d_sel:
//    slave owner: out_ma_HREADY/HRESP/HRDATA = sl_*[owner].
//    default owner: out_ma_HRDATA = 0; HREADY/HRESP from FSM.
//  - Default-slave FSM: IDLE, ERR1, ERR2.
//    IDLE: HREADY = 1, HRESP = OKAY.
//      -> ERR1 when out_ma_HREADY & no hit & ma_HTRANS[1] (NONSEQ/SEQ).
//    ERR1: HREADY = 0, HRESP = ERROR. -> ERR2 unconditionally.
//    ERR2: HREADY = 1, HRESP = ERROR.
//      -> ERR1 if a new unmapped NONSEQ/SEQ is accepted this cycle, else IDLE.
//  - IDLE/BUSY to an unmapped address: zero-wait OKAY; no error is counted.
//  - Counting: err_cnt += 1 and err_addr <= ma_HADDR on every IDLE/ERR2 -> ERR1 transition.
//    err_cnt saturates at all-ones.
//    err_clr has priority over an increment in the same cycle; err_clr forces both to 0.
//  - Latency: decode is 0 cycles. Slave responses pass through combinationally.
//    A default-slave ERROR takes exactly 2 data-phase cycles.
//  - Async reset mid-transfer (incl. ERR1): all state returns to reset values immediately.
//    out_ma_HREADY = 1 and HRESP = OKAY while HRESETn is low.
// TESTING
//  1 Map s0=0x4000_0000, s1=0x4000_1000, mask 0xFFFF_F000.
//    NONSEQ read 0x4000_1004 -> HSEL=2'b10; next cycle HRDATA = sl_HRDATA[63:32], HRESP = 00.
//  2 s0 stalls sl_HREADY=0 for 3 cycles on a write to 0x4000_0008.
//    -> out_ma_HREADY low 3 cycles; d_sel holds s0; the next address is not re-decoded until HREADY=1.
//  3 NONSEQ to 0x5000_0000 -> cycle1 HREADY=0/HRESP=01; cycle2 HREADY=1/HRESP=01.
//    err_cnt=1, err_addr=0x5000_0000.
//  4 Back-to-back unmapped NONSEQs at 0x6000_0000 and 0x6000_0004 -> ERR1,ERR2,ERR1,ERR2.
//    err_cnt=2, err_addr=0x6000_0004. An IDLE to the same address -> OKAY, count unchanged.
//  5 W_ERRCNT=2: 5 unmapped accesses -> err_cnt saturates at 3.
//    err_clr together with a 6th error -> err_cnt=0.
//  6 Assert HRESETn=0 during ERR1 -> immediately HREADY=1, HRESP=00, err_cnt=0.
//    First transfer after release decodes normally.

Source files
------------

// File: rtl/ahb_lite_slave_mux_if.sv
// ============================================================================
// Module   : ahb_lite_slave_mux_if
// Brief    : AHB-Lite bus bundle between one master, the slave mux and N slaves
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_lite_slave_mux_if #(
    parameter int N_SLAVE = 4,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic [W_ADDR-1:0]         ma_HADDR;
    logic [1:0]                ma_HTRANS;
    logic                      out_ma_HREADY;
    logic [1:0]                out_ma_HRESP;
    logic [W_DATA-1:0]         out_ma_HRDATA;
    logic [N_SLAVE-1:0]        out_sl_HSEL;
    logic [N_SLAVE-1:0]        sl_HREADY;
    logic [N_SLAVE*2-1:0]      sl_HRESP;
    logic [N_SLAVE*W_DATA-1:0] sl_HRDATA;

    // View of the bus master.
    modport master (
        output ma_HADDR, ma_HTRANS,
        input  out_ma_HREADY, out_ma_HRESP, out_ma_HRDATA
    );

    // View of the slave group.
    modport slave (
        input  out_sl_HSEL, out_ma_HREADY,
        output sl_HREADY, sl_HRESP, sl_HRDATA
    );

    // View of the decoder/mux itself.
    modport mux (
        input  ma_HADDR, ma_HTRANS, sl_HREADY, sl_HRESP, sl_HRDATA,
        output out_ma_HREADY, out_ma_HRESP, out_ma_HRDATA, out_sl_HSEL
    );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_slave_mux.sv
// ============================================================================
// Module   : ahb_lite_slave_mux
// Brief    : AHB-Lite address decoder, response mux and ERROR-only default slave
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_slave_mux #(
    parameter int                          N_SLAVE        = 4,
    parameter int                          W_ADDR         = 32,
    parameter int                          W_DATA         = 32,
    parameter logic [N_SLAVE*W_ADDR-1:0]   ADDR_START_MAP = {N_SLAVE{W_ADDR'(32'h0)}},
    parameter logic [N_SLAVE*W_ADDR-1:0]   ADDR_MASK      = {N_SLAVE{W_ADDR'(32'hFFFF_F000)}},
    parameter int                          W_ERRCNT       = 16
) (
    input  wire logic                HCLK,
    input  wire logic                HRESETn,
    ahb_lite_slave_mux_if.mux        bus,
    output logic [W_ERRCNT-1:0]      err_cnt,
    output logic [W_ADDR-1:0]        err_addr,
    input  wire logic                err_clr
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ERR1 = 2'd1;
    localparam logic [1:0] c_ST_ERR2 = 2'd2;

    localparam logic [1:0] c_RESP_OKAY  = 2'b00;
    localparam logic [1:0] c_RESP_ERROR = 2'b01;

    localparam logic [N_SLAVE:0] c_DSEL_DEFAULT = {1'b1, {N_SLAVE{1'b0}}};

    logic [N_SLAVE-1:0]  w_hit;
    logic [N_SLAVE-1:0]  w_sel;
    logic                w_any_hit;

    logic [N_SLAVE:0]    r_d_sel;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic                w_def_ready;
    logic [1:0]          w_def_resp;

    logic                w_ready;
    logic [1:0]          w_resp;
    logic [W_DATA-1:0]   w_rdata;

    logic                w_err_accept;
    logic [W_ERRCNT-1:0] r_err_cnt;
    logic [W_ADDR-1:0]   r_err_addr;

    wire                 w_unused_ok = &{1'b0, bus.ma_HTRANS[0]};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_hit
        assign w_hit[gi] = ((bus.ma_HADDR ^ ADDR_START_MAP[gi*W_ADDR +: W_ADDR])
                           & ADDR_MASK[gi*W_ADDR +: W_ADDR]) == '0;
    end

    // Walk from the top so that the lowest matching index is the last writer.
    always_comb begin
        w_sel = '0;
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end
        end
    end

    assign w_any_hit       = |w_hit;
    assign bus.out_sl_HSEL = w_sel;

    // ------------------------------------------------------------------
    // Data-phase owner
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_d_sel <= c_DSEL_DEFAULT;
        end else if (w_ready) begin
            r_d_sel <= {~w_any_hit, w_sel};
        end
    end

    // ------------------------------------------------------------------
    // Default-slave FSM
    // ------------------------------------------------------------------
    assign w_err_accept = w_ready & ~w_any_hit & bus.ma_HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_err_accept) w_state_nxt = c_ST_ERR1;
            c_ST_ERR1: w_state_nxt = c_ST_ERR2;
            c_ST_ERR2: w_state_nxt = w_err_accept ? c_ST_ERR1 : c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_def_ready = 1'b1;
        w_def_resp  = c_RESP_OKAY;
        case (r_state)
            c_ST_ERR1: begin
                w_def_ready = 1'b0;
                w_def_resp  = c_RESP_ERROR;
            end
            c_ST_ERR2: begin
                w_def_ready = 1'b1;
                w_def_resp  = c_RESP_ERROR;
            end
            default: begin
                w_def_ready = 1'b1;
                w_def_resp  = c_RESP_OKAY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response mux (owner is one-hot, so at most one slave term applies)
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = w_def_ready;
        w_resp  = w_def_resp;
        w_rdata = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (r_d_sel[i]) begin
                w_ready = bus.sl_HREADY[i];
                w_resp  = bus.sl_HRESP[i*2 +: 2];
                w_rdata = bus.sl_HRDATA[i*W_DATA +: W_DATA];
            end
        end
    end

    assign bus.out_ma_HREADY = w_ready;
    assign bus.out_ma_HRESP  = w_resp;
    assign bus.out_ma_HRDATA = w_rdata;

    // ------------------------------------------------------------------
    // Debug: saturating unmapped-access counter and last faulting address
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else if (err_clr) begin
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else if (w_err_accept) begin
            if (~&r_err_cnt) begin
                r_err_cnt <= r_err_cnt + W_ERRCNT'(1);
            end
            r_err_addr <= bus.ma_HADDR;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_addr = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_slave_mux.sv
// ============================================================================
// Module   : tb_ahb_lite_slave_mux
// Brief    : Directed self-checking bench for ahb_lite_slave_mux
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_slave_mux;

    localparam int N  = 2;
    localparam int WA = 32;
    localparam int WD = 32;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic HCLK;
    logic HRESETn;
    logic err_clr;
    logic [15:0]   err_cnt;
    logic [WA-1:0] err_addr;
    logic [1:0]    err_cnt2;
    logic [WA-1:0] err_addr2;

    int total = 0;
    int bad   = 0;

    ahb_lite_slave_mux_if #(.N_SLAVE(N), .W_ADDR(WA), .W_DATA(WD)) bus  ();
    ahb_lite_slave_mux_if #(.N_SLAVE(N), .W_ADDR(WA), .W_DATA(WD)) bus2 ();

    ahb_lite_slave_mux #(
        .N_SLAVE(N), .W_ADDR(WA), .W_DATA(WD),
        .ADDR_START_MAP({32'h4000_1000, 32'h4000_0000}),
        .ADDR_MASK({2{32'hFFFF_F000}}),
        .W_ERRCNT(16)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
        .err_cnt(err_cnt), .err_addr(err_addr), .err_clr(err_clr)
    );

    ahb_lite_slave_mux #(
        .N_SLAVE(N), .W_ADDR(WA), .W_DATA(WD),
        .ADDR_START_MAP({32'h4000_1000, 32'h4000_0000}),
        .ADDR_MASK({2{32'hFFFF_F000}}),
        .W_ERRCNT(2)
    ) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2),
        .err_cnt(err_cnt2), .err_addr(err_addr2), .err_clr(err_clr)
    );

    // Second instance mirrors the traffic of the first.
    assign bus2.ma_HADDR  = bus.ma_HADDR;
    assign bus2.ma_HTRANS = bus.ma_HTRANS;
    assign bus2.sl_HREADY = bus.sl_HREADY;
    assign bus2.sl_HRESP  = bus.sl_HRESP;
    assign bus2.sl_HRDATA = bus.sl_HRDATA;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic [WA-1:0] addr, input logic [1:0] trans);
        bus.ma_HADDR  = addr;
        bus.ma_HTRANS = trans;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        err_clr = 1'b0;
        drive(32'h0, T_IDLE);
        bus.sl_HREADY = 2'b11;
        bus.sl_HRESP  = 4'b0000;
        bus.sl_HRDATA = {32'hBBBB_0001, 32'hAAAA_0000};

        // Reset state
        settle();
        check("rst_hready", 64'(bus.out_ma_HREADY), 64'd1);
        check("rst_hresp",  64'(bus.out_ma_HRESP),  64'd0);
        check("rst_errcnt", 64'(err_cnt),           64'd0);
        check("rst_erraddr", 64'(err_addr),         64'd0);
        check("rst_hsel_unmapped", 64'(bus.out_sl_HSEL), 64'd0);
        cyc();
        HRESETn = 1'b1;

        // 1: read from s1
        cyc(); drive(32'h4000_1004, T_NONSEQ); settle();
        check("t1_hsel", 64'(bus.out_sl_HSEL), 64'b10);
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t1_rdata", 64'(bus.out_ma_HRDATA), 64'hBBBB_0001);
        check("t1_hresp", 64'(bus.out_ma_HRESP),  64'd0);
        check("t1_hready", 64'(bus.out_ma_HREADY), 64'd1);

        // 2: s0 stalls for 3 cycles while the next address targets s1
        cyc(); drive(32'h4000_0008, T_NONSEQ); settle();
        check("t2_hsel_s0", 64'(bus.out_sl_HSEL), 64'b01);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 0) begin
                bus.sl_HREADY = 2'b10;
                bus.sl_HRDATA = {32'hBBBB_0001, 32'hAAAA_1111};
                drive(32'h4000_1000, T_NONSEQ);
            end
            settle();
            check("t2_stall_hready", 64'(bus.out_ma_HREADY), 64'd0);
            check("t2_stall_owner",  64'(bus.out_ma_HRDATA), 64'hAAAA_1111);
        end
        check("t2_hsel_next", 64'(bus.out_sl_HSEL), 64'b10);
        cyc(); bus.sl_HREADY = 2'b11; settle();
        check("t2_release", 64'(bus.out_ma_HREADY), 64'd1);
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t2_next_owner", 64'(bus.out_ma_HRDATA), 64'hBBBB_0001);

        // 3: single unmapped NONSEQ
        cyc(); drive(32'h5000_0000, T_NONSEQ); settle();
        check("t3_hsel", 64'(bus.out_sl_HSEL), 64'd0);
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t3_c1_hready", 64'(bus.out_ma_HREADY), 64'd0);
        check("t3_c1_hresp",  64'(bus.out_ma_HRESP),  64'd1);
        check("t3_c1_rdata",  64'(bus.out_ma_HRDATA), 64'd0);
        cyc(); settle();
        check("t3_c2_hready", 64'(bus.out_ma_HREADY), 64'd1);
        check("t3_c2_hresp",  64'(bus.out_ma_HRESP),  64'd1);
        check("t3_errcnt",    64'(err_cnt),  64'd1);
        check("t3_erraddr",   64'(err_addr), 64'h5000_0000);
        cyc(); settle();
        check("t3_after_hresp", 64'(bus.out_ma_HRESP), 64'd0);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0; settle();
        check("clr_errcnt",  64'(err_cnt),  64'd0);
        check("clr_erraddr", 64'(err_addr), 64'd0);

        // 4: back-to-back unmapped NONSEQs, then an unmapped IDLE
        cyc(); drive(32'h6000_0000, T_NONSEQ);
        cyc(); drive(32'h6000_0004, T_NONSEQ); settle();
        check("t4_err1a", 64'({bus.out_ma_HREADY, bus.out_ma_HRESP}), 64'b001);
        cyc(); settle();
        check("t4_err2a", 64'({bus.out_ma_HREADY, bus.out_ma_HRESP}), 64'b101);
        cyc(); drive(32'h6000_0004, T_IDLE); settle();
        check("t4_err1b", 64'({bus.out_ma_HREADY, bus.out_ma_HRESP}), 64'b001);
        cyc(); settle();
        check("t4_err2b", 64'({bus.out_ma_HREADY, bus.out_ma_HRESP}), 64'b101);
        check("t4_errcnt",  64'(err_cnt),  64'd2);
        check("t4_erraddr", 64'(err_addr), 64'h6000_0004);
        cyc(); settle();
        check("t4_idle_okay", 64'({bus.out_ma_HREADY, bus.out_ma_HRESP}), 64'b100);
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t4_idle_cnt", 64'(err_cnt), 64'd2);

        // 5: saturation of the 2-bit counter, and clear beating an increment
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(); drive(32'h7000_0000 + 32'(k * 4), T_NONSEQ);
            cyc();
        end
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t5_cnt16", 64'(err_cnt),   64'd5);
        check("t5_cnt2",  64'(err_cnt2),  64'd3);
        check("t5_addr2", 64'(err_addr2), 64'h7000_0010);
        cyc(); drive(32'h7000_0100, T_NONSEQ); err_clr = 1'b1;
        cyc(); drive(32'h4000_0000, T_IDLE);   err_clr = 1'b0; settle();
        check("t5_clr_cnt2",  64'(err_cnt2), 64'd0);
        check("t5_clr_cnt16", 64'(err_cnt),  64'd0);
        check("t5_clr_addr",  64'(err_addr), 64'd0);
        check("t5_clr_err1",  64'({bus.out_ma_HREADY, bus.out_ma_HRESP}), 64'b001);
        cyc(); cyc();

        // 6: asynchronous reset in the middle of ERR1
        cyc(); drive(32'h8000_0000, T_NONSEQ);
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t6_in_err1", 64'(bus.out_ma_HREADY), 64'd0);
        check("t6_cnt_pre", 64'(err_cnt), 64'd1);
        #1 HRESETn = 1'b0;
        #1;
        check("t6_rst_hready", 64'(bus.out_ma_HREADY), 64'd1);
        check("t6_rst_hresp",  64'(bus.out_ma_HRESP),  64'd0);
        check("t6_rst_cnt",    64'(err_cnt), 64'd0);
        cyc(); HRESETn = 1'b1; drive(32'h4000_1008, T_NONSEQ); settle();
        check("t6_post_hsel", 64'(bus.out_sl_HSEL), 64'b10);
        cyc(); drive(32'h4000_0000, T_IDLE); settle();
        check("t6_post_rdata", 64'(bus.out_ma_HRDATA), 64'hBBBB_0001);
        check("t6_post_hresp", 64'(bus.out_ma_HRESP),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
